// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, constants and geometry helpers for dmem_ctrl
package dmem_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 4;

  function automatic int bytes_of(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int align_mask(input int data_w);
    return (data_w / 8) - 1;
  endfunction

endpackage

// File: rtl/dmem_resp_pipe.sv
// rtl/dmem_resp_pipe.sv - fixed-latency shift register carrying {valid, err, rdata}
module dmem_resp_pipe #(
  parameter int DATA_W = 32,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_err,
  input  logic [DATA_W-1:0] in_rdata,
  output logic              out_valid,
  output logic              out_err,
  output logic [DATA_W-1:0] out_rdata
);

  logic [LAT-1:0]    vld;
  logic [LAT-1:0]    err;
  logic [DATA_W-1:0] dat [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      err <= '0;
      for (int i = 0; i < LAT; i++) dat[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      err[0] <= in_err;
      dat[0] <= in_rdata;
      for (int i = 1; i < LAT; i++) begin
        vld[i] <= vld[i-1];
        err[i] <= err[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[LAT-1];
  assign out_err   = err[LAT-1];
  assign out_rdata = dat[LAT-1];

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - byte-addressed data memory with clear engine and fixed-latency responses
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int ADDR_W          = 16,
  parameter int DEPTH           = 65536,
  parameter int READ_LAT        = 1,
  parameter int ALLOW_UNALIGNED = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_start,
  output logic                  busy,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_W/8-1:0]   req_be,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err
);

  localparam int BYTES  = bytes_of(DATA_W);
  localparam int WORDS  = DEPTH / BYTES;
  localparam int CNT_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int MEM_AW = $clog2(DEPTH);

  if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_lat
    $error("dmem_ctrl: READ_LAT out of range");
  end

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = '0;
    busy       = 1'b0;
    req_ready  = 1'b0;
    case (state)
      ST_CLEAR: begin
        busy     = 1'b1;
        cnt_next = cnt + 1'b1;
        if (cnt == CNT_W'(WORDS - 1)) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end
      end
      ST_RUN: begin
        req_ready = 1'b1;
        if (clr_start) state_next = ST_CLEAR;
      end
      default: state_next = ST_CLEAR;
    endcase
  end

  // Range check carries one extra bit so addresses near the top cannot wrap.
  logic              accept;
  logic [ADDR_W:0]   last_byte;
  logic              range_err;
  logic              align_err;
  logic              req_err;
  logic              wr_en;
  logic              rd_en;
  logic [MEM_AW-1:0] base;

  assign accept    = req_valid & req_ready;
  assign last_byte = {1'b0, req_addr} + (ADDR_W+1)'(BYTES - 1);
  assign range_err = last_byte >= (ADDR_W+1)'(DEPTH);
  assign align_err = (ALLOW_UNALIGNED == 0) &&
                     ((req_addr & ADDR_W'(align_mask(DATA_W))) != '0);
  assign req_err   = range_err | align_err;
  assign wr_en     = accept & ~req_err & (|req_be);
  assign rd_en     = accept & ~req_err & ~(|req_be);
  assign base      = req_addr[MEM_AW-1:0];

  logic [7:0]        mem [DEPTH];
  logic [DATA_W-1:0] rd_word;

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < BYTES; k++) rd_word[8*k +: 8] = mem[base + MEM_AW'(k)];
  end

  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      for (int k = 0; k < BYTES; k++) mem[MEM_AW'(int'(cnt) * BYTES + k)] <= 8'h00;
    end else if (wr_en) begin
      for (int k = 0; k < BYTES; k++)
        if (req_be[k]) mem[base + MEM_AW'(k)] <= req_wdata[8*k +: 8];
    end
  end

  dmem_resp_pipe #(
    .DATA_W (DATA_W),
    .LAT    (READ_LAT)
  ) u_resp_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (accept),
    .in_err    (accept & req_err),
    .in_rdata  (rd_en ? rd_word : '0),
    .out_valid (resp_valid),
    .out_err   (resp_err),
    .out_rdata (resp_rdata)
  );

endmodule
